// File: rtl/lut_capture_ctrl.sv
// Capture/readout sequencer for the registered-output debug sample LUT.
// Ports: arm/abort/trig/post_len/din/din_valid/rd_req in; LUT write/read
//   port drives (ram_*), readout stream (rd_*), trig_addr, done, state out.
module lut_capture_ctrl #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 256,
    localparam int AWIDTH = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              arm,
    input  logic              abort,
    input  logic              trig,
    input  logic [AWIDTH-1:0] post_len,
    input  logic [WIDTH-1:0]  din,
    input  logic              din_valid,
    input  logic              rd_req,
    output logic              ram_we,
    output logic [AWIDTH-1:0] ram_wr_addr,
    output logic [WIDTH-1:0]  ram_din,
    output logic              ram_re,
    output logic [AWIDTH-1:0] ram_rd_addr,
    input  logic [WIDTH-1:0]  ram_dout,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_valid,
    output logic              rd_last,
    output logic [AWIDTH-1:0] trig_addr,
    output logic              done,
    output logic [2:0]        state
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ARMED = 3'd1;
    localparam logic [2:0] POST  = 3'd2;
    localparam logic [2:0] DONE  = 3'd3;
    localparam logic [2:0] READ  = 3'd4;

    localparam logic [AWIDTH-1:0] LAST = AWIDTH'(DEPTH - 1);
    localparam logic [AWIDTH-1:0] ONE  = AWIDTH'(1);

    logic [2:0]        state_q,     state_d;
    logic [AWIDTH-1:0] wr_ptr_q,    wr_ptr_d;
    logic [AWIDTH-1:0] post_cnt_q,  post_cnt_d;
    logic [AWIDTH-1:0] trig_addr_q, trig_addr_d;
    logic [AWIDTH-1:0] rd_ptr_q,    rd_ptr_d;
    logic [AWIDTH-1:0] rd_cnt_q,    rd_cnt_d;
    logic              ram_re_q,    ram_re_d;
    logic              rd_valid_q,  rd_valid_d;
    logic              rd_last_q,   rd_last_d;
    logic              wr_en;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        post_cnt_d  = post_cnt_q;
        trig_addr_d = trig_addr_q;
        rd_ptr_d    = rd_ptr_q;
        rd_cnt_d    = rd_cnt_q;
        ram_re_d    = ram_re_q;

        wr_en = din_valid & ~abort
              & ((state_q == ARMED) | (state_q == POST));

        // LUT output register lags ram_re by one cycle
        rd_valid_d = ram_re_q & ~abort;
        rd_last_d  = ram_re_q & ~abort & (rd_cnt_q == LAST);

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + ONE;
        end

        if (abort) begin
            state_d  = IDLE;
            ram_re_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (arm) begin
                        state_d  = ARMED;
                        wr_ptr_d = '0;
                    end
                end
                ARMED: begin
                    if (trig && din_valid) begin
                        trig_addr_d = wr_ptr_q;
                        post_cnt_d  = post_len;
                        state_d     = (post_len == '0) ? DONE : POST;
                    end
                end
                POST: begin
                    if (din_valid) begin
                        post_cnt_d = post_cnt_q - ONE;
                        if (post_cnt_q == ONE) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    if (rd_req) begin
                        // write pointer addresses the oldest sample
                        state_d  = READ;
                        ram_re_d = 1'b1;
                        rd_ptr_d = wr_ptr_q;
                        rd_cnt_d = '0;
                    end
                end
                READ: begin
                    if (rd_cnt_q == LAST) begin
                        state_d  = IDLE;
                        ram_re_d = 1'b0;
                    end else begin
                        rd_ptr_d = rd_ptr_q + ONE;
                        rd_cnt_d = rd_cnt_q + ONE;
                    end
                end
                default: begin
                    state_d  = IDLE;
                    ram_re_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            post_cnt_q  <= '0;
            trig_addr_q <= '0;
            rd_ptr_q    <= '0;
            rd_cnt_q    <= '0;
            ram_re_q    <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            post_cnt_q  <= post_cnt_d;
            trig_addr_q <= trig_addr_d;
            rd_ptr_q    <= rd_ptr_d;
            rd_cnt_q    <= rd_cnt_d;
            ram_re_q    <= ram_re_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
        end
    end

    assign ram_we      = wr_en;
    assign ram_wr_addr = wr_ptr_q;
    assign ram_din     = din;
    assign ram_re      = ram_re_q;
    assign ram_rd_addr = rd_ptr_q;
    // gate keeps rd_data at zero whenever the stream is idle or squashed
    assign rd_data     = rd_valid_q ? ram_dout : '0;
    assign rd_valid    = rd_valid_q;
    assign rd_last     = rd_last_q;
    assign trig_addr   = trig_addr_q;
    assign done        = (state_q == DONE);
    assign state       = state_q;

endmodule

// File: tb/tb_lut_capture_ctrl.sv
// Testbench for lut_capture_ctrl with a behavioural LUT and reference model.
// Directed scenarios followed by a randomized run.
module tb_lut_capture_ctrl;

    localparam int W  = 8;
    localparam int D  = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          resetn;
    logic          arm, abort, trig, din_valid, rd_req;
    logic [AW-1:0] post_len;
    logic [W-1:0]  din;
    logic          ram_we, ram_re, rd_valid, rd_last, done;
    logic [AW-1:0] ram_wr_addr, ram_rd_addr, trig_addr;
    logic [W-1:0]  ram_din, ram_dout, rd_data;
    logic [2:0]    state;

    lut_capture_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .resetn(resetn), .arm(arm), .abort(abort),
        .trig(trig), .post_len(post_len), .din(din),
        .din_valid(din_valid), .rd_req(rd_req),
        .ram_we(ram_we), .ram_wr_addr(ram_wr_addr), .ram_din(ram_din),
        .ram_re(ram_re), .ram_rd_addr(ram_rd_addr), .ram_dout(ram_dout),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
        .trig_addr(trig_addr), .done(done), .state(state)
    );

    always #5 clk = ~clk;

    // Behavioural LUT: registered output, zero when re is low
    logic [W-1:0] lut [D];
    bit           lut_init = 1'b0;
    always @(posedge clk) begin
        if (!lut_init) begin
            for (int i = 0; i < D; i++) lut[i] <= W'(i * 37 + 11);
            lut_init <= 1'b1;
            ram_dout <= '0;
        end else begin
            if (ram_we) lut[ram_wr_addr] <= ram_din;
            ram_dout <= ram_re ? lut[ram_rd_addr] : '0;
        end
    end

    // Reference model
    localparam int S_IDLE = 0, S_ARMED = 1, S_POST = 2, S_DONE = 3, S_READ = 4;
    int           m_st, m_wp, m_cnt, m_trig, m_raddr, m_issued;
    bit           m_re, m_rv, m_rl;
    logic [W-1:0] m_rdata;
    logic [W-1:0] img [D];

    int           n_cmp = 0;
    int           n_err = 0;
    logic [W-1:0] beats[$];
    int           last_idx;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_st = S_IDLE; m_wp = 0; m_cnt = 0; m_trig = 0;
        m_raddr = 0; m_issued = 0;
        m_re = 0; m_rv = 0; m_rl = 0; m_rdata = '0;
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_state"}, 32'(state), 0);
        chk({p, "_we"}, 32'(ram_we), 0);
        chk({p, "_re"}, 32'(ram_re), 0);
        chk({p, "_rv"}, 32'(rd_valid), 0);
        chk({p, "_rl"}, 32'(rd_last), 0);
        chk({p, "_done"}, 32'(done), 0);
        chk({p, "_wa"}, 32'(ram_wr_addr), 0);
        chk({p, "_ra"}, 32'(ram_rd_addr), 0);
        chk({p, "_ta"}, 32'(trig_addr), 0);
        chk({p, "_rd"}, 32'(rd_data), 0);
    endtask

    task automatic cyc(input bit a, input bit ab, input bit t,
                       input logic [AW-1:0] pl, input logic [W-1:0] d,
                       input bit dv, input bit rq);
        bit           we, nrv, nrl;
        logic [W-1:0] nrd;
        int           owp;
        arm = a; abort = ab; trig = t; post_len = pl;
        din = d; din_valid = dv; rd_req = rq;
        #1;
        we = dv && (m_st == S_ARMED || m_st == S_POST) && !ab;
        chk("ram_we", 32'(ram_we), 32'(we));
        chk("ram_wr_addr", 32'(ram_wr_addr), 32'(m_wp));
        chk("ram_din", 32'(ram_din), 32'(d));
        @(posedge clk);
        owp = m_wp;
        nrv = m_re && !ab;
        nrl = nrv && (m_issued == D);
        nrd = nrv ? img[m_raddr] : '0;
        if (we) begin
            img[m_wp] = d;
            m_wp = (m_wp + 1) % D;
        end
        if (ab) begin
            m_st = S_IDLE; m_re = 0;
        end else begin
            case (m_st)
                S_IDLE: if (a) begin m_st = S_ARMED; m_wp = 0; end
                S_ARMED: if (t && dv) begin
                    m_trig = owp;
                    if (pl == 0) m_st = S_DONE;
                    else begin m_st = S_POST; m_cnt = int'(pl); end
                end
                S_POST: if (dv) begin
                    m_cnt--;
                    if (m_cnt == 0) m_st = S_DONE;
                end
                S_DONE: if (rq) begin
                    m_st = S_READ; m_re = 1;
                    m_raddr = m_wp; m_issued = 1;
                end
                S_READ: if (m_issued == D) begin
                    m_st = S_IDLE; m_re = 0;
                end else begin
                    m_raddr = (m_raddr + 1) % D; m_issued++;
                end
                default: m_st = S_IDLE;
            endcase
        end
        m_rv = nrv; m_rl = nrl; m_rdata = nrd;
        #1;
        chk("state", 32'(state), 32'(m_st));
        chk("trig_addr", 32'(trig_addr), 32'(m_trig));
        chk("done", 32'(done), 32'(m_st == S_DONE));
        chk("ram_re", 32'(ram_re), 32'(m_re));
        if (m_re) chk("ram_rd_addr", 32'(ram_rd_addr), 32'(m_raddr));
        chk("rd_valid", 32'(rd_valid), 32'(m_rv));
        chk("rd_last", 32'(rd_last), 32'(m_rl));
        chk("rd_data", 32'(rd_data), 32'(m_rdata));
        if (rd_valid) begin
            beats.push_back(rd_data);
            if (rd_last) last_idx = beats.size() - 1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, '0, '0, 0, 0);
    endtask

    task automatic clr();
        beats.delete();
        last_idx = -1;
    endtask

    initial begin
        logic [AW-1:0] tr0;
        int            guard;
        for (int i = 0; i < D; i++) img[i] = W'(i * 37 + 11);
        model_reset();
        clr();
        resetn = 1'b0;
        arm = 0; abort = 0; trig = 0; post_len = '0;
        din = '0; din_valid = 0; rd_req = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("rst");
        resetn = 1'b1;

        // Nominal capture and readout
        clr();
        cyc(1, 0, 0, 5, 0, 0, 0);
        for (int i = 0; i < 40; i++) begin
            cyc(0, 0, i == 20, 5, W'(i), 1, 0);
            if (i == 24) chk("t2_post", 32'(state), 2);
            if (i == 25) chk("t2_done", 32'(state), 3);
        end
        chk("t2_trig_addr", 32'(trig_addr), 4);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("t2_done_drop", 32'(done), 0);
        idle(18);
        chk("t2_nbeats", beats.size(), 16);
        for (int i = 0; i < beats.size(); i++)
            chk("t2_beat", 32'(beats[i]), 32'(10 + i));
        chk("t2_last_idx", 32'(last_idx), 15);
        chk("t2_idle", 32'(state), 0);

        // Zero post length
        clr();
        cyc(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            cyc(0, 0, i == 3, 0, W'(i), 1, 0);
            if (i == 3) chk("t3_done", 32'(state), 3);
        end
        chk("t3_trig_addr", 32'(trig_addr), 3);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("t3_rd_start", 32'(ram_rd_addr), 4);
        idle(18);
        chk("t3_nbeats", beats.size(), 16);
        if (beats.size() == 16)
            for (int i = 0; i < 4; i++)
                chk("t3_tail", 32'(beats[12 + i]), 32'(i));
        chk("t3_last_idx", 32'(last_idx), 15);

        // Gapped input, trig on an invalid cycle is ignored
        clr();
        tr0 = trig_addr;
        cyc(1, 0, 0, 3, 0, 0, 0);
        for (int i = 0; i < 30; i++) begin
            cyc(0, 0, (i == 9) || (i == 14), 3, W'(i), (i % 2) == 0, 0);
            if (i == 9) begin
                chk("t4_ign_ta", 32'(trig_addr), 32'(tr0));
                chk("t4_ign_st", 32'(state), 1);
            end
            if (i == 19) chk("t4_post", 32'(state), 2);
            if (i == 20) chk("t4_done", 32'(state), 3);
        end
        chk("t4_trig_addr", 32'(trig_addr), 7);
        cyc(0, 0, 0, 0, 0, 0, 1);
        idle(18);
        chk("t4_nbeats", beats.size(), 16);
        if (beats.size() == 16)
            for (int i = 0; i < 4; i++)
                chk("t4_tail", 32'(beats[12 + i]), 32'(14 + 2 * i));

        // Abort mid-readout
        clr();
        cyc(1, 0, 0, 4, 0, 0, 0);
        for (int i = 0; i < 20; i++) cyc(0, 0, i == 2, 4, W'(i), 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        guard = 0;
        while (beats.size() < 7 && guard < 20) begin
            idle(1);
            guard++;
        end
        chk("t5_seven", beats.size(), 7);
        cyc(0, 1, 0, 0, 0, 0, 0);
        chk("t5_re", 32'(ram_re), 0);
        chk("t5_rv", 32'(rd_valid), 0);
        chk("t5_st", 32'(state), 0);
        idle(20);
        chk("t5_nolast", 32'(last_idx), 32'(-1));
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("t5_wr0", 32'(ram_wr_addr), 0);
        cyc(0, 1, 0, 0, 0, 0, 0);

        // Ignored controls
        clr();
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 8'h5a, 1, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("t6_arm_done", 32'(state), 3);
        cyc(0, 0, 0, 0, 0, 0, 1);
        idle(18);
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0);
        chk("t6_arm_abort", 32'(state), 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("t6_rq_armed_re", 32'(ram_re), 0);
        chk("t6_rq_armed_st", 32'(state), 1);
        cyc(0, 1, 0, 0, 0, 0, 0);

        // Async reset mid-POST with data flowing
        cyc(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 0, i == 1, 10, W'(i), 1, 0);
        chk("t1_in_post", 32'(state), 2);
        din_valid = 1; din = 8'hc3;
        resetn = 1'b0;
        #1;
        chk_reset("arst");
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 3, W'(i), 1, 0);

        // Randomized run
        for (int n = 0; n < 3000; n++) begin
            if (beats.size() > 64) clr();
            cyc($urandom_range(0, 11) == 0, $urandom_range(0, 79) == 0,
                $urandom_range(0, 9) == 0, AW'($urandom_range(0, 6)),
                W'($urandom), $urandom_range(0, 3) != 0,
                $urandom_range(0, 5) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
